nco_ctrl: RTL and testbench

//  Update scheduler for one carrier/code NCO in a GPS tracking channel. Accepts step (frequency)

---
 rtl/nco_ctrl.sv | 151 +++++++++++++++
 tb/tb_nco_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/nco_ctrl.sv
// Epoch-aligned update scheduler for one tracking-channel NCO: shadows host/loop writes
// and applies them on code epochs. Optional epoch counter enabled by NCO_CTRL_EPOCH_CNT_EN.
module nco_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             epoch,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic             host_sel_phase,
  input  logic [WIDTH-1:0] host_data,
  input  logic             loop_valid,
  output logic             loop_ready,
  input  logic [WIDTH-1:0] loop_step,
  output logic             nco_enable,
  output logic             nco_phase_sync,
  output logic [WIDTH-1:0] nco_phase_in,
  output logic [WIDTH-1:0] nco_step,
`ifdef NCO_CTRL_EPOCH_CNT_EN
  output logic [15:0]      epoch_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_EP = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_step_pend;
  logic             r_phase_pend;
  logic [WIDTH-1:0] r_step_sh;
  logic [WIDTH-1:0] r_phase_sh;
  logic             r_enable;
  logic             r_phase_sync;
  logic [WIDTH-1:0] r_phase_in;
  logic [WIDTH-1:0] r_step;
`ifdef NCO_CTRL_EPOCH_CNT_EN
  logic [15:0]      r_epoch_cnt;
`endif

  logic w_host_acc;
  logic w_loop_acc;

  // The host always wins the step slot when both sources request it together.
  assign host_ready = host_sel_phase ? !r_phase_pend : !r_step_pend;
  assign loop_ready = !r_step_pend && !(host_valid && !host_sel_phase);
  assign w_host_acc = host_valid && host_ready;
  assign w_loop_acc = loop_valid && loop_ready;

  assign nco_enable     = r_enable;
  assign nco_phase_sync = r_phase_sync;
  assign nco_phase_in   = r_phase_in;
  assign nco_step       = r_step;
  assign busy           = r_step_pend || r_phase_pend;
`ifdef NCO_CTRL_EPOCH_CNT_EN
  assign epoch_cnt      = r_epoch_cnt;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_step_pend  <= 1'b0;
      r_phase_pend <= 1'b0;
      r_step_sh    <= '0;
      r_phase_sh   <= '0;
      r_enable     <= 1'b0;
      r_phase_sync <= 1'b0;
      r_phase_in   <= '0;
      r_step       <= '0;
`ifdef NCO_CTRL_EPOCH_CNT_EN
      r_epoch_cnt  <= '0;
`endif
    end else begin
      r_phase_sync <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_enable <= 1'b0;
          if (r_step_pend) begin
            r_step      <= r_step_sh;
            r_step_pend <= 1'b0;
          end
          if (run) r_state <= S_WAIT_EP;
        end
        S_WAIT_EP: begin
          r_enable <= 1'b0;
          if (!run) begin
            r_state <= S_IDLE;
          end else if (epoch) begin
            r_phase_in   <= r_phase_sh;
            r_phase_sync <= 1'b1;
            r_enable     <= 1'b1;
            if (r_step_pend) r_step <= r_step_sh;
            r_step_pend  <= 1'b0;
            r_phase_pend <= 1'b0;
            r_state      <= S_RUN;
`ifdef NCO_CTRL_EPOCH_CNT_EN
            r_epoch_cnt  <= '0;
`endif
          end
        end
        S_RUN: begin
          if (!run) begin
            r_enable <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_enable <= 1'b1;
            if (epoch) begin
              if (r_step_pend) begin
                r_step      <= r_step_sh;
                r_step_pend <= 1'b0;
              end
              if (r_phase_pend) begin
                r_phase_in   <= r_phase_sh;
                r_phase_sync <= 1'b1;
                r_phase_pend <= 1'b0;
              end
`ifdef NCO_CTRL_EPOCH_CNT_EN
              r_epoch_cnt <= r_epoch_cnt + 16'd1;
`endif
            end
          end
        end
        default: begin
          r_enable <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase

      // New writes land after the apply logic so a write taken on an epoch edge
      // keeps its pend flag and waits for the following epoch.
      if (w_host_acc && host_sel_phase) begin
        r_phase_sh   <= host_data;
        r_phase_pend <= 1'b1;
      end
      if (w_host_acc && !host_sel_phase) begin
        r_step_sh   <= host_data;
        r_step_pend <= 1'b1;
      end
      if (w_loop_acc) begin
        r_step_sh   <= loop_step;
        r_step_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nco_ctrl.sv
// Directed, table-driven bench for nco_ctrl: one record per clock cycle with inputs,
// the combinational readies expected before the edge and the registered outputs after it.
module tb_nco_ctrl;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          run, epoch;
  logic          host_valid, host_sel_phase;
  logic [W-1:0]  host_data;
  logic          host_ready;
  logic          loop_valid;
  logic [W-1:0]  loop_step;
  logic          loop_ready;
  logic          nco_enable, nco_phase_sync;
  logic [W-1:0]  nco_phase_in, nco_step;
  logic          busy;
`ifdef NCO_CTRL_EPOCH_CNT_EN
  logic [15:0]   epoch_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nco_ctrl #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .epoch          (epoch),
    .host_valid     (host_valid),
    .host_ready     (host_ready),
    .host_sel_phase (host_sel_phase),
    .host_data      (host_data),
    .loop_valid     (loop_valid),
    .loop_ready     (loop_ready),
    .loop_step      (loop_step),
    .nco_enable     (nco_enable),
    .nco_phase_sync (nco_phase_sync),
    .nco_phase_in   (nco_phase_in),
    .nco_step       (nco_step),
`ifdef NCO_CTRL_EPOCH_CNT_EN
    .epoch_cnt      (epoch_cnt),
`endif
    .busy           (busy)
  );

  typedef struct {
    logic         run, epoch, hv, hs;
    logic [W-1:0] hd;
    logic         lv;
    logic [W-1:0] ld;
    logic         hr, lr;
    logic         en, sy;
    logic [W-1:0] pi, st;
    logic         bz;
  } vec_t;

  localparam int NV = 24;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic e, logic hv, logic hs, logic [W-1:0] hd,
                              logic lv, logic [W-1:0] ld, logic hr, logic lr,
                              logic en, logic sy, logic [W-1:0] pi, logic [W-1:0] st,
                              logic bz);
    vec_t v;
    v.run = r;  v.epoch = e; v.hv = hv; v.hs = hs; v.hd = hd;
    v.lv = lv;  v.ld = ld;   v.hr = hr; v.lr = lr;
    v.en = en;  v.sy = sy;   v.pi = pi; v.st = st; v.bz = bz;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic hv, input logic hs,
                       input logic [W-1:0] hd, input logic lv, input logic [W-1:0] ld);
    run = r; epoch = e; host_valid = hv; host_sel_phase = hs;
    host_data = hd; loop_valid = lv; loop_step = ld;
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_out"}, {nco_enable, nco_phase_sync, nco_phase_in, nco_step, busy},
        {1'b0, 1'b0, 32'h0, 32'h0, 1'b0});
    chk({name, "_rdy"}, {host_ready, loop_ready}, 2'b11);
  endtask

  initial begin
    // run epoch hv hs hd          lv ld     | hr lr | en sy pi           st           bz
    tbl[0]  = mk(0,0, 1,0,32'h0000_1000, 0,32'h0,  1,0, 0,0,32'h0,        32'h0,        1);
    tbl[1]  = mk(0,0, 0,0,32'h0,         0,32'h0,  0,0, 0,0,32'h0,        32'h0000_1000,0);
    tbl[2]  = mk(0,0, 1,1,32'h8000_0000, 0,32'h0,  1,1, 0,0,32'h0,        32'h0000_1000,1);
    tbl[3]  = mk(1,0, 0,0,32'h0,         0,32'h0,  1,1, 0,0,32'h0,        32'h0000_1000,1);
    tbl[4]  = mk(1,0, 0,0,32'h0,         0,32'h0,  1,1, 0,0,32'h0,        32'h0000_1000,1);
    tbl[5]  = mk(1,1, 0,0,32'h0,         0,32'h0,  1,1, 1,1,32'h8000_0000,32'h0000_1000,0);
    tbl[6]  = mk(1,0, 0,0,32'h0,         0,32'h0,  1,1, 1,0,32'h8000_0000,32'h0000_1000,0);
    tbl[7]  = mk(1,0, 1,0,32'h10,        1,32'h20, 1,0, 1,0,32'h8000_0000,32'h0000_1000,1);
    tbl[8]  = mk(1,0, 0,0,32'h0,         1,32'h20, 0,0, 1,0,32'h8000_0000,32'h0000_1000,1);
    tbl[9]  = mk(1,1, 0,0,32'h0,         1,32'h20, 0,0, 1,0,32'h8000_0000,32'h10,       0);
    tbl[10] = mk(1,0, 0,0,32'h0,         1,32'h20, 1,1, 1,0,32'h8000_0000,32'h10,       1);
    tbl[11] = mk(1,1, 0,0,32'h0,         0,32'h0,  0,0, 1,0,32'h8000_0000,32'h20,       0);
    tbl[12] = mk(1,1, 0,0,32'h0,         1,32'h55, 1,1, 1,0,32'h8000_0000,32'h20,       1);
    tbl[13] = mk(1,0, 0,0,32'h0,         0,32'h0,  0,0, 1,0,32'h8000_0000,32'h20,       1);
    tbl[14] = mk(1,1, 0,0,32'h0,         0,32'h0,  0,0, 1,0,32'h8000_0000,32'h55,       0);
    tbl[15] = mk(1,0, 0,0,32'h0,         1,32'h77, 1,1, 1,0,32'h8000_0000,32'h55,       1);
    tbl[16] = mk(0,1, 0,0,32'h0,         0,32'h0,  0,0, 0,0,32'h8000_0000,32'h55,       1);
    tbl[17] = mk(0,0, 0,0,32'h0,         0,32'h0,  0,0, 0,0,32'h8000_0000,32'h77,       0);
    tbl[18] = mk(0,0, 1,1,32'h1234_5678, 0,32'h0,  1,1, 0,0,32'h8000_0000,32'h77,       1);
    tbl[19] = mk(1,0, 0,0,32'h0,         0,32'h0,  1,1, 0,0,32'h8000_0000,32'h77,       1);
    tbl[20] = mk(1,1, 1,1,32'hDEAD_BEEF, 0,32'h0,  0,1, 1,1,32'h1234_5678,32'h77,       0);
    tbl[21] = mk(1,1, 1,1,32'hCAFE_0001, 0,32'h0,  1,1, 1,0,32'h1234_5678,32'h77,       1);
    tbl[22] = mk(1,1, 0,0,32'h0,         0,32'h0,  1,1, 1,1,32'hCAFE_0001,32'h77,       0);
    tbl[23] = mk(1,0, 0,0,32'h0,         0,32'h0,  1,1, 1,0,32'hCAFE_0001,32'h77,       0);

    reset = 1'b1;
    drive(0, 0, 0, 0, '0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    chk_idle_outputs("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_idle_outputs("reset_release");

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].run, tbl[i].epoch, tbl[i].hv, tbl[i].hs, tbl[i].hd, tbl[i].lv, tbl[i].ld);
      #1;
      chk($sformatf("row%0d_ready", i), {host_ready, loop_ready}, {tbl[i].hr, tbl[i].lr});
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_out", i),
          {nco_enable, nco_phase_sync, nco_phase_in, nco_step, busy},
          {tbl[i].en, tbl[i].sy, tbl[i].pi, tbl[i].st, tbl[i].bz});
    end

    // Running channel with a pending step: reset must drop it and zero every output.
    @(negedge clk);
    drive(1, 0, 1, 0, 32'h0000_ABCD, 0, '0);
    @(posedge clk);
    #1;
    chk("midop_pend", {busy, nco_enable}, 2'b11);
    @(negedge clk);
    drive(0, 0, 0, 0, '0, 0, '0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_idle_outputs("midop_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midop_discard", {nco_step, busy}, {32'h0, 1'b0});

    // run dropped while waiting for the first epoch: back to IDLE with no sync.
    @(negedge clk);
    drive(1, 0, 0, 0, '0, 0, '0);
    @(negedge clk);
    drive(0, 1, 0, 0, '0, 0, '0);
    @(posedge clk);
    #1;
    chk("waitep_abort", {nco_enable, nco_phase_sync}, 2'b00);
    @(negedge clk);
    drive(0, 1, 0, 0, '0, 0, '0);
    @(posedge clk);
    #1;
    chk("idle_epoch_ignored", {nco_enable, nco_phase_sync}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, got hang expected finish");
    $fatal(1);
  end

endmodule
